// File: rtl/mpu_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package mpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_REQUEST = 2'd2,
    S_ISSUE   = 2'd3
  } seq_state_t;

  // Fragment tags (top two bits of a fragment)
  localparam logic [1:0] TAG_LO  = 2'b00;
  localparam logic [1:0] TAG_MID = 2'b01;
  localparam logic [1:0] TAG_HI  = 2'b10;
  localparam logic [1:0] TAG_CMD = 2'b11;

  // Command payloads carried under TAG_CMD
  localparam logic [5:0] CMD_COMMIT = 6'h3F;
  localparam logic [5:0] CMD_CLEAR  = 6'h00;

  // Field placement inside the assembled instruction
  localparam int LO_LSB  = 0;
  localparam int MID_LSB = 6;
  localparam int HI_LSB  = 12;

  // Mask bit positions {H,M,L}
  localparam int MASK_L = 0;
  localparam int MASK_M = 1;
  localparam int MASK_H = 2;

endpackage

// File: rtl/frag_buffer.sv
// Instruction assembly buffer: field writes by tag plus the {H,M,L} mask.
module frag_buffer
  import mpu_pkg::*;
#(
  parameter int DWORD = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [1:0]       tag,
  input  logic [5:0]       payload,
  input  logic             clear,
  output logic [DWORD-1:0] buf_data,
  output logic [2:0]       mask
);

  // Clear has priority; otherwise a field write overwrites its slice (last write wins).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_data <= '0;
      mask     <= '0;
    end else if (clear) begin
      buf_data <= '0;
      mask     <= '0;
    end else if (wr_en) begin
      case (tag)
        TAG_LO: begin
          buf_data[LO_LSB +: 6] <= payload;
          mask[MASK_L]          <= 1'b1;
        end
        TAG_MID: begin
          buf_data[MID_LSB +: 6] <= payload;
          mask[MASK_M]           <= 1'b1;
        end
        TAG_HI: begin
          // Only four high bits exist; payload[5:4] is dropped.
          buf_data[HI_LSB +: 4] <= payload[3:0];
          mask[MASK_H]          <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Collects tagged fragments, requests a context slot and issues 16-bit instructions.
//
// Handshakes: a fragment transfers on a rising edge where frag_valid && frag_ready;
// an instruction transfers on a rising edge where instr_valid && instr_ready.
// Valid holds its payload stable until the transfer; ready never depends on valid.
// The context slot is granted on an edge where context_request && ack.
module instr_fetch_sequencer
  import mpu_pkg::*;
#(
  parameter int WORD        = 8,
  parameter int DWORD       = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frag_valid,
  output logic             frag_ready,
  input  logic [WORD-1:0]  frag,
  output logic             context_request,
  input  logic             ack,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [DWORD-1:0] instruction,
  output logic             timeout_err,
  output logic             busy
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  seq_state_t       state, state_nx;
  logic [CW-1:0]    wait_cnt;
  logic [1:0]       tag;
  logic [5:0]       payload;
  logic             frag_accept;
  logic             field_wr, buf_clear, err_set, load_instr;
  logic [DWORD-1:0] buf_data;
  logic [2:0]       mask;

  assign tag         = frag[WORD-1 -: 2];
  assign payload     = frag[5:0];
  assign frag_accept = frag_valid && frag_ready;

  // Moore outputs decoded from state alone
  assign frag_ready      = (state == S_IDLE) || (state == S_COLLECT);
  assign context_request = (state == S_REQUEST);
  assign instr_valid     = (state == S_ISSUE);
  assign busy            = (state == S_REQUEST) || (state == S_ISSUE);

  frag_buffer #(.DWORD(DWORD)) u_frag_buffer (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (field_wr),
    .tag      (tag),
    .payload  (payload),
    .clear    (buf_clear),
    .buf_data (buf_data),
    .mask     (mask)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and control strobes
  always_comb begin
    state_nx   = state;
    field_wr   = 1'b0;
    buf_clear  = 1'b0;
    err_set    = 1'b0;
    load_instr = 1'b0;
    unique case (state)
      S_IDLE, S_COLLECT: begin
        if (frag_accept) begin
          if (tag != TAG_CMD) begin
            field_wr = 1'b1;
            state_nx = S_COLLECT;
          end else if (payload == CMD_COMMIT) begin
            state_nx = S_REQUEST;
          end else if (payload == CMD_CLEAR) begin
            buf_clear = 1'b1;
            state_nx  = S_IDLE;
          end
        end
      end
      S_REQUEST: begin
        // A grant on the last allowed cycle beats the timeout.
        if (ack) begin
          load_instr = 1'b1;
          state_nx   = S_ISSUE;
        end else if (wait_cnt == CW'(ACK_TIMEOUT - 1)) begin
          err_set   = 1'b1;
          buf_clear = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          buf_clear = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Wait counter: runs only while staying in REQUEST, so it never exceeds ACK_TIMEOUT-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                           wait_cnt <= '0;
    else if (state == S_REQUEST && state_nx == S_REQUEST) wait_cnt <= wait_cnt + CW'(1);
    else                                                  wait_cnt <= '0;
  end

  // Sticky timeout flag, cleared by the next accepted fragment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           timeout_err <= 1'b0;
    else if (err_set)     timeout_err <= 1'b1;
    else if (frag_accept) timeout_err <= 1'b0;
  end

  // Output instruction register, captured on the grant and held afterwards
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          instruction <= '0;
    else if (load_instr) instruction <= buf_data;
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer with hand-computed expected values.
module tb_instr_fetch_sequencer;

  localparam int WORD        = 8;
  localparam int DWORD       = 16;
  localparam int ACK_TIMEOUT = 15;

  logic             clk;
  logic             reset;
  logic             frag_valid;
  logic             frag_ready;
  logic [WORD-1:0]  frag;
  logic             context_request;
  logic             ack;
  logic             instr_valid;
  logic             instr_ready;
  logic [DWORD-1:0] instruction;
  logic             timeout_err;
  logic             busy;

  int errors = 0;
  int checks = 0;
  int cr_count = 0;
  int vld_count = 0;
  int cr_base, vld_base;
  logic [DWORD-1:0] exp_q[$];

  instr_fetch_sequencer #(
    .WORD(WORD), .DWORD(DWORD), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .frag_valid      (frag_valid),
    .frag_ready      (frag_ready),
    .frag            (frag),
    .context_request (context_request),
    .ack             (ack),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instruction     (instruction),
    .timeout_err     (timeout_err),
    .busy            (busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counters for request and valid width, sampled mid-cycle
  always @(negedge clk) begin
    if (context_request) cr_count++;
    if (instr_valid)     vld_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one fragment and return 1ns after the edge that accepts it
  task automatic send_frag(input logic [WORD-1:0] f);
    int n;
    n = 0;
    frag       = f;
    frag_valid = 1'b1;
    while (!frag_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("frag_ready_wait", 32'(frag_ready), 32'd1);
    @(posedge clk); #1;
    frag_valid = 1'b0;
  endtask

  // Compare the presented instruction against the oldest expected word
  task automatic expect_issue(input string tag);
    logic [DWORD-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(instr_valid), 32'd1);
      check({tag, "_instr"}, 32'(instruction), 32'(e));
    end
  endtask

  initial begin
    int n;
    reset = 1'b0; frag_valid = 1'b0; frag = '0; ack = 1'b0; instr_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr", 32'(instruction), 32'd0);
    check("rst_creq",  32'(context_request), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_terr",  32'(timeout_err), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_fready", 32'(frag_ready), 32'd1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // 1: full assembly, ack and ready held high -> minimum latency
    ack = 1'b1; instr_ready = 1'b1;
    send_frag(8'h05); send_frag(8'h4A); send_frag(8'h83);
    exp_q.push_back(16'h3285);
    vld_base = vld_count;
    send_frag(8'hFF);
    check("t1_creq",   32'(context_request), 32'd1);
    check("t1_fready", 32'(frag_ready), 32'd0);
    check("t1_busy",   32'(busy), 32'd1);
    check("t1_novalid", 32'(instr_valid), 32'd0);
    @(posedge clk); #1;
    expect_issue("t1");
    @(posedge clk); #1;
    check("t1_valid_off", 32'(instr_valid), 32'd0);
    check("t1_pulse",  32'(vld_count - vld_base), 32'd1);
    check("t1_hold",   32'(instruction), 32'h3285);
    check("t1_fready_back", 32'(frag_ready), 32'd1);

    // 2: rewrite L, ignored command, ack after 3 waiting cycles
    ack = 1'b0;
    send_frag(8'h01); send_frag(8'hC5); send_frag(8'h02);
    exp_q.push_back(16'h0002);
    send_frag(8'hFF);
    cr_base = cr_count;
    repeat (3) begin @(posedge clk); #1; end
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    expect_issue("t2");
    check("t2_creq_off", 32'(context_request), 32'd0);
    check("t2_creq_len", 32'(cr_count - cr_base), 32'd4);
    @(posedge clk); #1;

    // 3: timeout with no ack
    vld_base = vld_count;
    send_frag(8'hFF);
    cr_base = cr_count;
    n = 0;
    while (busy && n < 40) begin @(posedge clk); #1; n++; end
    check("t3_exit",    32'(busy), 32'd0);
    check("t3_creq_len", 32'(cr_count - cr_base), 32'd15);
    check("t3_terr",    32'(timeout_err), 32'd1);
    check("t3_fready",  32'(frag_ready), 32'd1);
    check("t3_novalid", 32'(vld_count - vld_base), 32'd0);
    send_frag(8'h05);
    check("t3_terr_clr", 32'(timeout_err), 32'd0);

    // 3b: ack on the last allowed cycle wins over the timeout
    exp_q.push_back(16'h0005);
    send_frag(8'hFF);
    cr_base = cr_count;
    repeat (14) begin @(posedge clk); #1; end
    check("t3b_creq_last", 32'(context_request), 32'd1);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    expect_issue("t3b");
    check("t3b_terr",  32'(timeout_err), 32'd0);
    check("t3b_creq_len", 32'(cr_count - cr_base), 32'd15);
    @(posedge clk); #1;

    // 4: CLEAR empties the buffer before COMMIT
    ack = 1'b1;
    send_frag(8'h3F);
    send_frag(8'hC0);
    check("t4_clear_idle", 32'(frag_ready), 32'd1);
    exp_q.push_back(16'h0000);
    send_frag(8'hFF);
    @(posedge clk); #1;
    expect_issue("t4");
    @(posedge clk); #1;

    // 5: backpressure in ISSUE; HI payload bits [5:4] ignored
    instr_ready = 1'b0;
    send_frag(8'hB3); send_frag(8'h41);
    exp_q.push_back(16'h3040);
    send_frag(8'hFF);
    @(posedge clk); #1;
    expect_issue("t5");
    frag = 8'h05; frag_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t5_stable", 32'(instruction), 32'h3040);
      check("t5_fready", 32'(frag_ready), 32'd0);
      check("t5_valid",  32'(instr_valid), 32'd1);
    end
    instr_ready = 1'b1;
    @(posedge clk); #1;
    frag_valid = 1'b0;
    check("t5_fready_rise", 32'(frag_ready), 32'd1);
    check("t5_valid_off",   32'(instr_valid), 32'd0);
    exp_q.push_back(16'h0000);
    send_frag(8'hFF);
    @(posedge clk); #1;
    expect_issue("t5b");
    @(posedge clk); #1;

    // 6: reset asserted mid-REQUEST
    ack = 1'b0;
    send_frag(8'h83);
    send_frag(8'hFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6_in_req", 32'(context_request), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_creq",   32'(context_request), 32'd0);
    check("t6_valid",  32'(instr_valid), 32'd0);
    check("t6_busy",   32'(busy), 32'd0);
    check("t6_fready", 32'(frag_ready), 32'd1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    ack = 1'b1;
    exp_q.push_back(16'h0000);
    send_frag(8'hFF);
    @(posedge clk); #1;
    expect_issue("t6");
    check("t6_terr", 32'(timeout_err), 32'd0);
    @(posedge clk); #1;

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
